servile_rr_arbiter: RTL and testbench

N-port Wishbone arbiter for Servile-based systems, generalising the fixed two-port ibus/dbus arbiter to `NUM_MASTERS` requesters sharing a single memory port. Uses registered round-robin grant with the grant locked until slave ack. Sits between the CPU buses (and any DMA or debug masters) and the shared memory Wishbone port. An optional watchdog terminates transactions the slave never acknowledges.

---
 rtl/servile_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_servile_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_rr_arbiter.sv
// servile_rr_arbiter
// N-port Wishbone classic arbiter in front of a single shared memory port.
// Registered round-robin grant, locked until the slave acknowledges.
// Optional watchdog enabled by defining SERVILE_ARB_TIMEOUT_EN: a granted
// transaction that sees no slave ack for TIMEOUT busy cycles is terminated
// with ack+err to the granted master.
module servile_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [32*NUM_MASTERS-1:0] i_m_adr,
   input  logic [32*NUM_MASTERS-1:0] i_m_dat,
   input  logic [4*NUM_MASTERS-1:0]  i_m_sel,
   input  logic [NUM_MASTERS-1:0]    i_m_we,
   input  logic [NUM_MASTERS-1:0]    i_m_stb,
   output logic [31:0]               o_m_rdt,
   output logic [NUM_MASTERS-1:0]    o_m_ack,
   output logic [NUM_MASTERS-1:0]    o_m_err,
   output logic [NUM_MASTERS-1:0]    o_grant,
   output logic                      o_busy,
   output logic [31:0]               o_wb_mem_adr,
   output logic [31:0]               o_wb_mem_dat,
   output logic [3:0]                o_wb_mem_sel,
   output logic                      o_wb_mem_we,
   output logic                      o_wb_mem_stb,
   input  logic [31:0]               i_wb_mem_rdt,
   input  logic                      i_wb_mem_ack
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_idx_next;
   logic [IW-1:0]   r_last;
   logic [IW-1:0]   w_last_next;
   logic [IW-1:0]   w_pick;
   logic            w_found;
   logic            w_busy;
   logic            w_timeout;
   logic            w_done;
   logic [NUM_MASTERS-1:0] w_onehot;

   // Per-master request fields unpacked into arrays for indexed muxing.
   logic [31:0] w_adr [NUM_MASTERS];
   logic [31:0] w_dat [NUM_MASTERS];
   logic [3:0]  w_sel [NUM_MASTERS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
         assign w_adr[gi] = i_m_adr[32*gi +: 32];
         assign w_dat[gi] = i_m_dat[32*gi +: 32];
         assign w_sel[gi] = i_m_sel[4*gi +: 4];
      end
   endgenerate

   assign w_busy = (r_state == S_BUSY);

   // Round-robin pick: first requester scanning last+1, last+2, ... mod N.
   always_comb begin
      logic [IW-1:0] v_cand;
      int            v_sum;
      w_pick  = '0;
      w_found = 1'b0;
      v_cand  = '0;
      v_sum   = 0;
      for (int off = 1; off <= NUM_MASTERS; off++) begin
         v_sum  = (int'(r_last) + off) % NUM_MASTERS;
         v_cand = IW'(v_sum);
         if (!w_found && i_m_stb[v_cand]) begin
            w_found = 1'b1;
            w_pick  = v_cand;
         end
      end
   end

`ifdef SERVILE_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

   // Watchdog counter: zero in the first busy cycle, counts ack-less busy cycles.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!w_busy) begin
         r_cnt <= '0;
      end else if (!i_wb_mem_ack) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // A real ack on the limit cycle takes precedence over the timeout.
   assign w_timeout = w_busy && !i_wb_mem_ack && (r_cnt == CNT_LIMIT);
`else
   logic [15:0] w_unused_timeout;
   assign w_unused_timeout = 16'(TIMEOUT);
   assign w_timeout        = 1'b0;
`endif

   assign w_done = w_busy && (i_wb_mem_ack || w_timeout);

   // State, grant index and round-robin pointer registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_last  <= IW'(NUM_MASTERS - 1);
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_last  <= w_last_next;
      end
   end

   // Next-state logic: grant in IDLE, release on ack or timeout in BUSY.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_last_next  = r_last;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_idx_next   = w_pick;
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_done) begin
               w_last_next  = r_idx;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath and handshake outputs; ack path is purely combinational.
   always_comb begin
      w_onehot     = '0;
      w_onehot[r_idx] = 1'b1;
      o_busy       = w_busy;
      o_grant      = w_busy ? w_onehot : '0;
      o_wb_mem_adr = w_adr[r_idx];
      o_wb_mem_dat = w_dat[r_idx];
      o_wb_mem_sel = w_sel[r_idx];
      o_wb_mem_we  = i_m_we[r_idx];
      o_wb_mem_stb = w_busy && i_m_stb[r_idx] && !w_timeout;
      o_m_ack      = w_done ? w_onehot : '0;
      o_m_err      = w_timeout ? w_onehot : '0;
      o_m_rdt      = w_timeout ? 32'd0 : i_wb_mem_rdt;
   end

endmodule

// File: tb/tb_servile_rr_arbiter.sv
// Directed testbench for servile_rr_arbiter (NUM_MASTERS=4, TIMEOUT=8).
// Expected acks are queued when stimulus is driven and popped by a monitor.
module tb_servile_rr_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic           clk = 1'b0;
   logic           i_rst_n;
   logic [32*N-1:0] i_m_adr;
   logic [32*N-1:0] i_m_dat;
   logic [4*N-1:0]  i_m_sel;
   logic [N-1:0]    i_m_we;
   logic [N-1:0]    i_m_stb;
   logic [31:0]     o_m_rdt;
   logic [N-1:0]    o_m_ack;
   logic [N-1:0]    o_m_err;
   logic [N-1:0]    o_grant;
   logic            o_busy;
   logic [31:0]     o_wb_mem_adr;
   logic [31:0]     o_wb_mem_dat;
   logic [3:0]      o_wb_mem_sel;
   logic            o_wb_mem_we;
   logic            o_wb_mem_stb;
   logic [31:0]     i_wb_mem_rdt;
   logic            i_wb_mem_ack;

   always #5 clk = ~clk;

   servile_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_m_adr      (i_m_adr),
      .i_m_dat      (i_m_dat),
      .i_m_sel      (i_m_sel),
      .i_m_we       (i_m_we),
      .i_m_stb      (i_m_stb),
      .o_m_rdt      (o_m_rdt),
      .o_m_ack      (o_m_ack),
      .o_m_err      (o_m_err),
      .o_grant      (o_grant),
      .o_busy       (o_busy),
      .o_wb_mem_adr (o_wb_mem_adr),
      .o_wb_mem_dat (o_wb_mem_dat),
      .o_wb_mem_sel (o_wb_mem_sel),
      .o_wb_mem_we  (o_wb_mem_we),
      .o_wb_mem_stb (o_wb_mem_stb),
      .i_wb_mem_rdt (i_wb_mem_rdt),
      .i_wb_mem_ack (i_wb_mem_ack)
   );

   typedef struct {
      logic [N-1:0] ack;
      logic [31:0]  rdt;
      logic [N-1:0] err;
   } exp_t;

   exp_t exp_q[$];
   int   exp_order[$];
   int   checks       = 0;
   int   failures     = 0;
   int   cyc_no       = 0;
   int   last_ack_cyc = -100;
   bit   oneshot      = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input int k, input logic [31:0] rdt, input bit err);
      exp_t e;
      e.ack    = '0;
      e.ack[k] = 1'b1;
      e.rdt    = rdt;
      e.err    = '0;
      e.err[k] = err;
      exp_q.push_back(e);
   endtask

   // Ack monitor: every master ack must match the head of the scoreboard.
   task automatic mon();
      exp_t e;
      if (o_m_ack !== '0 || o_m_err !== '0) begin
         last_ack_cyc = cyc_no;
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 64'({o_m_err, o_m_ack}), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ack_vec", 64'(o_m_ack), 64'(e.ack));
            chk("ack_rdt", 64'(o_m_rdt), 64'(e.rdt));
            chk("ack_err", 64'(o_m_err), 64'(e.err));
            $display("txn cyc=%0d ack=%b err=%b rdt=%08h", cyc_no, o_m_ack, o_m_err, o_m_rdt);
         end
      end
   endtask

   task automatic end_cycle();
      logic [N-1:0] acked;
      #1;
      mon();
      acked = o_m_ack;
      @(posedge clk);
      #1;
      cyc_no++;
      i_wb_mem_ack = 1'b0;
      if (oneshot) i_m_stb = i_m_stb & ~acked;
   endtask

   task automatic do_reset();
      i_rst_n      = 1'b0;
      i_m_stb      = '0;
      i_wb_mem_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      cyc_no++;
   endtask

   // Slave model acking `lat` cycles after stb; checks grant order and gap.
   task automatic run_rr(input int lat, input int budget);
      int n = 0;
      int wait_c = 0;
      int total;
      logic [N-1:0] exp_g;
      total = exp_order.size();
      for (int c = 0; c < budget && n < total; c++) begin
         #1;
         if (o_wb_mem_stb === 1'b1) begin
            if (wait_c == 0) begin
               exp_g = '0;
               exp_g[exp_order[n]] = 1'b1;
               chk("grant_order", 64'(o_grant), 64'(exp_g));
               chk("rearb_gap", 64'((cyc_no - last_ack_cyc) >= 2), 64'd1);
            end
            if (wait_c == lat) begin
               i_wb_mem_ack = 1'b1;
               i_wb_mem_rdt = o_wb_mem_adr ^ KEY;
               n++;
               wait_c = 0;
            end else begin
               wait_c++;
            end
         end
         end_cycle();
      end
      chk("rr_budget", 64'(n), 64'(total));
      exp_order.delete();
   endtask

   initial begin
      i_rst_n      = 1'b0;
      i_m_adr      = '0;
      i_m_dat      = '0;
      i_m_sel      = '0;
      i_m_we       = '0;
      i_m_stb      = '0;
      i_wb_mem_rdt = '0;
      i_wb_mem_ack = 1'b0;

      // Reset state
      do_reset();
      i_wb_mem_rdt = 32'h1234_5678;
      #1;
      chk("rst_ack", 64'(o_m_ack), 64'd0);
      chk("rst_err", 64'(o_m_err), 64'd0);
      chk("rst_grant", 64'(o_grant), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_stb", 64'(o_wb_mem_stb), 64'd0);
      chk("rst_rdt_follow", 64'(o_m_rdt), 64'h1234_5678);

      // Single transaction, slave acks two cycles after stb
      i_m_adr[31:0] = 32'h0000_0100;
      i_m_dat[31:0] = 32'hCAFE_0001;
      i_m_sel[3:0]  = 4'b1010;
      i_m_we[0]     = 1'b1;
      i_m_stb       = 4'b0001;
      push_exp(0, 32'hDEAD_BEEF, 1'b0);
      #1;
      chk("t1_c0_stb", 64'(o_wb_mem_stb), 64'd0);
      chk("t1_c0_grant", 64'(o_grant), 64'd0);
      end_cycle();
      #1;
      chk("t1_c1_stb", 64'(o_wb_mem_stb), 64'd1);
      chk("t1_c1_grant", 64'(o_grant), 64'b0001);
      chk("t1_adr", 64'(o_wb_mem_adr), 64'h100);
      chk("t1_dat", 64'(o_wb_mem_dat), 64'hCAFE_0001);
      chk("t1_sel", 64'(o_wb_mem_sel), 64'b1010);
      chk("t1_we", 64'(o_wb_mem_we), 64'd1);
      end_cycle();
      #1;
      chk("t1_c2_grant", 64'(o_grant), 64'b0001);
      chk("t1_c2_noack", 64'(o_m_ack), 64'd0);
      end_cycle();
      i_wb_mem_ack = 1'b1;
      i_wb_mem_rdt = 32'hDEAD_BEEF;
      #1;
      chk("t1_c3_grant", 64'(o_grant), 64'b0001);
      end_cycle();
      #1;
      chk("t1_c4_idle", 64'(o_busy), 64'd0);
      chk("t1_c4_stb", 64'(o_wb_mem_stb), 64'd0);
      end_cycle();

      // All four masters requesting continuously, slave acks immediately
      for (int k = 0; k < N; k++) i_m_adr[32*k +: 32] = 32'h1000 + 32'(4*k);
      do_reset();
      oneshot = 1'b0;
      i_m_stb = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         exp_order.push_back(j % N);
         push_exp(j % N, (32'h1000 + 32'(4*(j % N))) ^ KEY, 1'b0);
      end
      run_rr(0, 30);
      oneshot = 1'b1;

      // Masters 1 and 3 with last=3: 1 first, then 3
      do_reset();
      i_m_stb = 4'b1010;
      exp_order.push_back(1);
      exp_order.push_back(3);
      push_exp(1, 32'h1004 ^ KEY, 1'b0);
      push_exp(3, 32'h100C ^ KEY, 1'b0);
      run_rr(1, 20);

      // Reset in the middle of BUSY, followed by a late slave ack
      do_reset();
      i_m_stb = 4'b0001;
      end_cycle();
      #1;
      chk("t4_busy", 64'(o_busy), 64'd1);
      i_rst_n = 1'b0;
      end_cycle();
      i_rst_n      = 1'b1;
      i_wb_mem_ack = 1'b1;
      i_wb_mem_rdt = 32'h0000_0BAD;
      i_m_stb      = 4'b0101;
      #1;
      chk("t4_stb", 64'(o_wb_mem_stb), 64'd0);
      chk("t4_ack", 64'(o_m_ack), 64'd0);
      chk("t4_grant", 64'(o_grant), 64'd0);
      end_cycle();
      exp_order.push_back(0);
      exp_order.push_back(2);
      push_exp(0, 32'h1000 ^ KEY, 1'b0);
      push_exp(2, 32'h1008 ^ KEY, 1'b0);
      run_rr(1, 20);

      // Slave never acks
      do_reset();
      i_wb_mem_rdt = 32'hFFFF_FFFF;
      i_m_stb      = 4'b0100;
`ifdef SERVILE_ARB_TIMEOUT_EN
      push_exp(2, 32'd0, 1'b1);
      end_cycle();
      for (int b = 1; b <= TO; b++) begin
         #1;
         chk("to_busy", 64'(o_busy), 64'd1);
         if (b < TO) chk("to_noerr", 64'(o_m_err), 64'd0);
         end_cycle();
      end
      #1;
      chk("to_idle_after", 64'(o_busy), 64'd0);
      i_m_stb = 4'b0010;
      exp_order.push_back(1);
      push_exp(1, 32'h1004 ^ KEY, 1'b0);
      run_rr(0, 10);
`else
      end_cycle();
      for (int b = 1; b <= 40; b++) begin
         #1;
         chk("noto_busy", 64'(o_busy), 64'd1);
         chk("noto_err", 64'(o_m_err), 64'd0);
         end_cycle();
      end
`endif

      // Ack while idle with no requests
      do_reset();
      for (int b = 0; b < 3; b++) begin
         i_wb_mem_ack = 1'b1;
         #1;
         chk("idle_ack", 64'(o_m_ack), 64'd0);
         chk("idle_busy", 64'(o_busy), 64'd0);
         end_cycle();
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
